fifo_uart_tx_drain: RTL

Downstream consumer of the 16-deep byte FIFO. It pops one byte whenever the FIFO reports non-empty and transmission is enabled, then serializes the byte onto a single line as an 8N1 UART frame: one start bit, eight data bits LSB first, one stop bit. It drives the FIFO rd strobe directly and takes FIFO dout and EMPTY as inputs, completing the byte path from the FIFO to the serial pin.

---
 rtl/fifo_uart_tx_drain.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx_drain.sv
// Drains a byte FIFO onto a serial line as 8N1 UART frames (start, DATA_W bits LSB first, stop).
// One pop per frame; a frame in flight always completes unless reset intervenes.
module fifo_uart_tx_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              rd,
   output logic              tx,
   output logic              busy,
   output logic              tx_done,
   output logic [15:0]       frame_cnt
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_CAPT, S_START, S_DATA, S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [BAUD_W-1:0]   r_baud;
   logic [BIT_W-1:0]    r_bit;
   logic [DATA_W-1:0]   r_shreg;
   logic [DATA_W-1:0]   w_shifted;
   logic                r_rd;
   logic                r_tx;
   logic                r_busy;
   logic [15:0]         r_frame_cnt;
   logic                w_baud_end;
   logic                w_go;

   assign w_baud_end = (r_baud == BAUD_LAST);
   assign w_go       = (r_state == S_IDLE) && enable && !fifo_empty;
   assign w_shifted  = r_shreg >> 1;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_READ;
         S_READ:  w_next = S_CAPT;
         S_CAPT:  w_next = S_START;
         S_START: if (w_baud_end) w_next = S_DATA;
         S_DATA:  if (w_baud_end && (r_bit == BIT_LAST)) w_next = S_STOP;
         S_STOP:  if (w_baud_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The FIFO presents the popped byte one cycle after it samples rd, hence the READ/CAPT pair.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd        <= 1'b0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_frame_cnt <= 16'd0;
         r_baud      <= '0;
         r_bit       <= '0;
         r_shreg     <= '0;
      end else begin
         r_rd <= w_go;
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_go) r_busy <= 1'b1;
            end
            S_CAPT: begin
               r_shreg <= fifo_dout;
               r_tx    <= 1'b0;
               r_baud  <= '0;
            end
            S_START: begin
               if (w_baud_end) begin
                  r_tx   <= r_shreg[0];
                  r_bit  <= '0;
                  r_baud <= '0;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_shreg <= w_shifted;
                  r_bit   <= r_bit + BIT_W'(1);
                  r_tx    <= (r_bit == BIT_LAST) ? 1'b1 : w_shifted[0];
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud      <= '0;
                  r_busy      <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign rd        = r_rd;
   assign tx        = r_tx;
   assign busy      = r_busy;
   assign tx_done   = (r_state == S_STOP) && w_baud_end;
   assign frame_cnt = r_frame_cnt;

endmodule
